// File: rtl/data_mem_burst.sv
// Behavioural main memory with a fixed-latency in-order request pipeline and a read-response FIFO.
// Optional DMEM_CRITICAL_WORD_FIRST_EN rotates read lines so lane 0 is the addressed word.
module data_mem_burst #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [BURST_LEN*WORD_W-1:0] req_wdata_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [ADDR_W-1:0]           resp_addr_o,
  output logic [BURST_LEN*WORD_W-1:0] resp_rdata_o,
  output logic                        wr_done_o
);

  localparam int unsigned LineW = BURST_LEN * WORD_W;
  localparam int unsigned IdxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SumW  = CntW + 1;
  localparam int unsigned PtrW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  function automatic logic [IdxW-1:0] line_base(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = (32'(a) >> 2) & 32'(DEPTH_WORDS - 1);
    return IdxW'(w) & ~IdxW'(BURST_LEN - 1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RESP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Storage holds data XOR word index so that power-up zeroes read back as memory[i] = i.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic              pipe_valid_q [LATENCY];
  logic              pipe_write_q [LATENCY];
  logic [ADDR_W-1:0] pipe_addr_q  [LATENCY];
  logic [LineW-1:0]  pipe_wdata_q [LATENCY];

  logic [ADDR_W-1:0] fifo_addr_q [RESP_DEPTH];
  logic [LineW-1:0]  fifo_data_q [RESP_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic            wr_done_q;

  logic              accept, pop, push, wr_exit;
  logic [ADDR_W-1:0] exit_addr;
  logic [LineW-1:0]  exit_wdata;
  logic [IdxW-1:0]   exit_base;
  logic [LineW-1:0]  exit_line;

  assign req_ready_o = ~reset_i &&
                       (({1'b0, inflight_q} + {1'b0, count_q}) < SumW'(RESP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;

  assign resp_valid_o = (count_q != '0);
  assign pop          = resp_valid_o & resp_ready_i;
  assign resp_addr_o  = resp_valid_o ? fifo_addr_q[rd_ptr_q] : '0;
  assign resp_rdata_o = resp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign wr_done_o    = wr_done_q;

  assign exit_addr  = pipe_addr_q[LATENCY-1];
  assign exit_wdata = pipe_wdata_q[LATENCY-1];
  assign exit_base  = line_base(exit_addr);
  assign push       = pipe_valid_q[LATENCY-1] & ~pipe_write_q[LATENCY-1];
  assign wr_exit    = pipe_valid_q[LATENCY-1] &  pipe_write_q[LATENCY-1];

  always_comb begin
    logic [IdxW-1:0] widx;
    int unsigned     src;
`ifdef DMEM_CRITICAL_WORD_FIRST_EN
    int unsigned     off;
    off = (32'(exit_addr) >> 2) % BURST_LEN;
`endif
    exit_line = '0;
    for (int k = 0; k < int'(BURST_LEN); k++) begin
`ifdef DMEM_CRITICAL_WORD_FIRST_EN
      src = (off + k) % BURST_LEN;
`else
      src = k;
`endif
      widx = exit_base + IdxW'(src);
      exit_line[k*WORD_W +: WORD_W] = mem_q[widx] ^ WORD_W'(widx);
    end
  end

  always_comb begin
    count_d    = count_q + CntW'(push) - CntW'(pop);
    inflight_d = inflight_q + CntW'(accept & ~req_write_i) - CntW'(push);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_write_q[i] <= 1'b0;
        pipe_addr_q[i]  <= '0;
        pipe_wdata_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      pipe_valid_q[0] <= accept;
      pipe_write_q[0] <= req_write_i;
      pipe_addr_q[0]  <= req_addr_i;
      pipe_wdata_q[0] <= req_wdata_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_write_q[i] <= pipe_write_q[i-1];
        pipe_addr_q[i]  <= pipe_addr_q[i-1];
        pipe_wdata_q[i] <= pipe_wdata_q[i-1];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_done_q  <= wr_exit;
    end
  end

  // Contents survive reset; only the pipeline valids gate commits.
  always_ff @(posedge clock_i) begin
    if (wr_exit) begin
      for (int k = 0; k < int'(BURST_LEN); k++) begin
        mem_q[exit_base + IdxW'(k)] <=
            exit_wdata[k*WORD_W +: WORD_W] ^ WORD_W'(exit_base + IdxW'(k));
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= exit_addr;
      fifo_data_q[wr_ptr_q] <= exit_line;
    end
  end

endmodule
